// File: rtl/penalty_round_ctl.sv
// penalty_round_ctl: kick-by-kick match sequencer that judges goal/save and keeps score.
module penalty_round_ctl #(
  parameter int ROUNDS        = 5,
  parameter int MAX_ROUNDS    = 15,
  parameter int AIM_FRAMES    = 90,
  parameter int FLIGHT_FRAMES = 30,
  parameter int RESULT_FRAMES = 120,
  parameter int HIT_RADIUS    = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        match_start,
  input  logic        shot_req,
  input  logic [11:0] shot_xpos,
  input  logic [11:0] shot_ypos,
  input  logic [11:0] gloves_xpos,
  input  logic [11:0] gloves_ypos,
  output logic [2:0]  phase,
  output logic        kicker,
  output logic [3:0]  round_idx,
  output logic [3:0]  player_score,
  output logic [3:0]  cpu_score,
  output logic        ball_launch,
  output logic        goal_flag,
  output logic        save_flag,
  output logic [11:0] target_x,
  output logic [11:0] target_y,
  output logic        match_over,
  output logic [1:0]  winner
);
  localparam int MAXF = (AIM_FRAMES > FLIGHT_FRAMES ? AIM_FRAMES : FLIGHT_FRAMES) > RESULT_FRAMES ?
                        (AIM_FRAMES > FLIGHT_FRAMES ? AIM_FRAMES : FLIGHT_FRAMES) : RESULT_FRAMES;
  localparam int CW = MAXF > 1 ? $clog2(MAXF) : 1;
  typedef enum logic [2:0] {IDLE = 3'd0, AIM = 3'd1, FLIGHT = 3'd2, JUDGE = 3'd3, RESULT = 3'd4, DONE = 3'd5} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic kicker_n, launch_n, goal_n, save_n;
  logic [3:0] round_n, ps_n, cs_n, rnext;
  logic [11:0] tx_n, ty_n;
  logic [1:0] winner_n;
  logic signed [12:0] sx, sy;
  logic [12:0] dx, dy;
  logic hit;
  // Unsigned positions are zero-extended so the 13-bit difference never overflows.
  assign sx = $signed({1'b0, target_x}) - $signed({1'b0, gloves_xpos});
  assign sy = $signed({1'b0, target_y}) - $signed({1'b0, gloves_ypos});
  assign dx = sx[12] ? -sx : sx;
  assign dy = sy[12] ? -sy : sy;
  assign hit = dx <= 13'(HIT_RADIUS) && dy <= 13'(HIT_RADIUS);
  assign rnext = round_idx + 4'd1;
  assign phase = state;
  assign match_over = state == DONE;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    kicker_n = kicker;
    round_n = round_idx;
    ps_n = player_score;
    cs_n = cpu_score;
    tx_n = target_x;
    ty_n = target_y;
    winner_n = winner;
    goal_n = goal_flag;
    save_n = save_flag;
    launch_n = 1'b0;
    case (state)
      IDLE, DONE: if (match_start) begin
        state_n = AIM;
        cnt_n = '0;
        kicker_n = 1'b0;
        round_n = '0;
        ps_n = '0;
        cs_n = '0;
        winner_n = 2'b00;
        goal_n = 1'b0;
        save_n = 1'b0;
      end
      AIM: if (shot_req) begin
        tx_n = shot_xpos;
        ty_n = shot_ypos;
        launch_n = 1'b1;
        cnt_n = '0;
        state_n = FLIGHT;
      end else if (frame_tick) begin
        cnt_n = cnt == CW'(AIM_FRAMES - 1) ? '0 : cnt + CW'(1);
        save_n = cnt == CW'(AIM_FRAMES - 1);
        state_n = cnt == CW'(AIM_FRAMES - 1) ? RESULT : AIM;
      end
      FLIGHT: if (frame_tick) begin
        cnt_n = cnt == CW'(FLIGHT_FRAMES - 1) ? '0 : cnt + CW'(1);
        state_n = cnt == CW'(FLIGHT_FRAMES - 1) ? JUDGE : FLIGHT;
      end
      JUDGE: begin
        cnt_n = '0;
        state_n = RESULT;
        save_n = hit;
        goal_n = !hit;
        if (!hit && kicker) cs_n = cpu_score == 4'd15 ? cpu_score : cpu_score + 4'd1;
        if (!hit && !kicker) ps_n = player_score == 4'd15 ? player_score : player_score + 4'd1;
      end
      RESULT: if (frame_tick && cnt != CW'(RESULT_FRAMES - 1)) begin
        cnt_n = cnt + CW'(1);
      end else if (frame_tick) begin
        cnt_n = '0;
        goal_n = 1'b0;
        save_n = 1'b0;
        kicker_n = !kicker;
        state_n = AIM;
        // A round completes on the CPU kick; sudden death falls out of the unequal-score test.
        if (kicker && ((int'(rnext) >= ROUNDS && player_score != cpu_score) || int'(rnext) == MAX_ROUNDS)) begin
          state_n = DONE;
          winner_n = player_score > cpu_score ? 2'b01 : cpu_score > player_score ? 2'b10 : 2'b11;
        end else if (kicker) begin
          round_n = rnext;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      kicker <= 1'b0;
      round_idx <= '0;
      player_score <= '0;
      cpu_score <= '0;
      target_x <= '0;
      target_y <= '0;
      winner <= 2'b00;
      goal_flag <= 1'b0;
      save_flag <= 1'b0;
      ball_launch <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      kicker <= kicker_n;
      round_idx <= round_n;
      player_score <= ps_n;
      cpu_score <= cs_n;
      target_x <= tx_n;
      target_y <= ty_n;
      winner <= winner_n;
      goal_flag <= goal_n;
      save_flag <= save_n;
      ball_launch <= launch_n;
    end
  end
endmodule

// File: doc/penalty_round_ctl.md
Name: penalty_round_ctl

Overview:
- Match sequencer for the penalty game.
- Steps every kick through aim, flight, judge and result phases, and alternates the shooter between player and CPU.
- Judges goal or save from the latched shot position against the keeper gloves position, and keeps the score.
- Sits between the mouse/gloves path and the screen/ball control blocks: `phase`, `kicker` and `ball_launch` drive ball and screen control, and the scores feed the text overlay.

Parameters:
- ROUNDS, 5: regulation rounds; one round is one player kick plus one CPU kick.
- MAX_ROUNDS, 15: hard cap including sudden death; must be >= ROUNDS and <= 15.
- AIM_FRAMES, 90: frames allowed to shoot before the kick is forfeited.
- FLIGHT_FRAMES, 30: frames between launch and judgement.
- RESULT_FRAMES, 120: frames the goal/save result is held.
- HIT_RADIUS, 48: save half-window in pixels, compared on each axis.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- frame_tick  in  1  one-cycle pulse per video frame
- match_start  in  1  pulse; starts a new match
- shot_req  in  1  pulse; shooter commits a shot
- shot_xpos  in  12  shot target x, valid with shot_req
- shot_ypos  in  12  shot target y, valid with shot_req
- gloves_xpos  in  12  current keeper gloves x
- gloves_ypos  in  12  current keeper gloves y
- phase  out  3  0 IDLE, 1 AIM, 2 FLIGHT, 3 JUDGE, 4 RESULT, 5 DONE
- kicker  out  1  0 player shoots, 1 CPU shoots
- round_idx  out  4  current round, 0-based
- player_score  out  4  player goals
- cpu_score  out  4  CPU goals
- ball_launch  out  1  one-cycle pulse when a shot is accepted
- goal_flag  out  1  high during RESULT if the kick scored
- save_flag  out  1  high during RESULT if the kick was saved or forfeited
- target_x  out  12  latched shot x, held until the next accepted shot
- target_y  out  12  latched shot y, held until the next accepted shot
- match_over  out  1  high in DONE
- winner  out  2  00 none, 01 player, 10 CPU, 11 draw; valid in DONE

Behaviour:
- Reset values:
  - `phase` = IDLE; `kicker`, `round_idx`, scores, `target_x`/`target_y` = 0.
  - All flags and pulses = 0; `winner` = 00.
  - Frame counter = 0.
  - `rst` overrides everything, including mid-kick.
- IDLE or DONE, `match_start`=1:
  - Clear scores, `round_idx`, `kicker`, `winner`, `match_over` and flags.
  - Next cycle `phase`=AIM with frame counter 0.
  - `match_start` in any other phase is ignored.
- AIM:
  - Frame counter increments on `frame_tick`.
  - `shot_req`=1 latches the shot into `target_x`/`target_y`, pulses `ball_launch` the next cycle (1-cycle latency), clears the counter and moves to FLIGHT.
  - Timeout: `frame_tick` with counter == AIM_FRAMES-1 and no `shot_req` moves to RESULT with `save_flag`=1 (forfeit, no score).
  - `shot_req` and a timeout tick in the same cycle: the shot wins.
  - `shot_req` outside AIM is ignored.
- FLIGHT: counts `frame_tick`; on the tick with counter == FLIGHT_FRAMES-1, go to JUDGE.
- JUDGE (exactly 1 cycle):
  - dx = |target_x − gloves_xpos| and dy = |target_y − gloves_ypos|, using 13-bit signed subtraction, gloves sampled this cycle.
  - Save if dx <= HIT_RADIUS and dy <= HIT_RADIUS (inclusive); otherwise goal.
  - On goal, increment the kicker's score, saturating at 15.
  - Set `goal_flag` or `save_flag`, clear the counter and go to RESULT.
- RESULT:
  - Flags hold; on the tick with counter == RESULT_FRAMES-1, clear the flags and advance.
  - Advance with `kicker`=0: set `kicker`=1, go to AIM.
  - Advance with `kicker`=1 (round complete): set `kicker`=0, `rnext` = `round_idx`+1.
  - If `rnext` >= ROUNDS and scores differ: DONE.
  - Else if `rnext` == MAX_ROUNDS: DONE (draw if equal).
  - Else `round_idx` = `rnext`, go to AIM.
  - Sudden death applies automatically beyond ROUNDS: the match ends after the first complete round with unequal scores.
- DONE:
  - `match_over`=1.
  - `winner` = 01 if player > CPU, 10 if CPU > player, 11 if equal.
  - Scores and `round_idx` hold until `match_start`.
- Frame counter width is $clog2 of the largest frame parameter; it is cleared on every phase entry.

Test Plan:
Use ROUNDS=2, MAX_ROUNDS=3, AIM_FRAMES=4, FLIGHT_FRAMES=2, RESULT_FRAMES=2, HIT_RADIUS=48.
1. Assert rst mid-FLIGHT -> next cycle `phase`=0, scores 0, `ball_launch`=0, `target_x`/`target_y`=0; `shot_req` in IDLE -> no `ball_launch`.
2. `match_start`, `shot_req` at (100,100), gloves (300,300) -> `ball_launch` one cycle later, JUDGE after 2 ticks, `player_score`=1, `goal_flag`=1 for 2 ticks, then `kicker`=1, `phase`=AIM.
3. CPU kick at (200,200), gloves (248,152) -> dx=48, dy=48 -> `save_flag`=1, `cpu_score`=0; gloves (249,200) -> `goal_flag`=1.
4. AIM with no `shot_req` for 4 ticks -> RESULT with `save_flag`=1, no score change; `shot_req` on the 4th tick -> FLIGHT instead.
5. Two full rounds: player 2 goals, CPU 1 -> `match_over`=1, `winner`=01, `round_idx`=1; then `match_start` -> scores 0, `phase`=AIM.
6. Rounds tied 1-1 after round 1; round 2 both save -> DONE at MAX_ROUNDS=3 only if still tied -> `winner`=11; a CPU goal in round 2 -> `winner`=10 after round 2.
